// File: rtl/mode_arbiter_pkg.sv
// rtl/mode_arbiter_pkg.sv - shared mode encodings, arbiter states and dip_sw decode
package mode_arbiter_pkg;

  localparam logic [1:0] MODE_WATCH     = 2'd0;
  localparam logic [1:0] MODE_SET       = 2'd1;
  localparam logic [1:0] MODE_ALARM     = 2'd2;
  localparam logic [1:0] MODE_STOPWATCH = 2'd3;

  localparam logic [7:0] BLANK_CHAR_DEFAULT = 8'h20;

  typedef enum logic [1:0] {
    RUN,
    SETTLE,
    WAIT_FRAME,
    BLANK
  } arb_state_t;

  // Only clean one-hot patterns on the low three switches select a mode; anything else is watch.
  function automatic logic [1:0] decode_dip(input logic [3:0] dip);
    logic [1:0] mode;
    case (dip)
      4'b0001: mode = MODE_SET;
      4'b0010: mode = MODE_ALARM;
      4'b0100: mode = MODE_STOPWATCH;
      default: mode = MODE_WATCH;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/mode_arbiter_qualifier.sv
// rtl/mode_arbiter_qualifier.sv - dip_sw decode and settle counter producing target and qualified strobe
module mode_select_qualifier
  import mode_arbiter_pkg::*;
#(
  parameter int SETTLE_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dip_sw,
  input  logic [1:0] active_mode,
  input  logic       in_run,
  input  logic       in_settle,
  output logic       change,
  output logic [1:0] target,
  output logic       qualified
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYC - 1);

  logic [1:0]       decoded;
  logic [CNT_W-1:0] settle_cnt;

  assign decoded = decode_dip(dip_sw);

  // While running the reference is the committed mode; once a change is pending it is the target.
  assign change    = in_run ? (decoded != active_mode) : (decoded != target);
  assign qualified = in_settle && !change && (settle_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target     <= MODE_WATCH;
      settle_cnt <= '0;
    end else if (change) begin
      target     <= decoded;
      settle_cnt <= '0;
    end else if (in_settle && (settle_cnt != CNT_MAX)) begin
      settle_cnt <= settle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mode_arbiter.sv
// rtl/mode_arbiter.sv - LCD character path and switch arbiter across display modes; MODE_ARB_BLANK_EN adds a blank frame before commit
module mode_arbiter
  import mode_arbiter_pkg::*;
#(
  parameter int         SETTLE_CYC = 50000,
  parameter int         CHAR_NUM   = 32,
  parameter logic [7:0] BLANK_CHAR = BLANK_CHAR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dip_sw,
  input  logic [3:0] sw_pulse,
  input  logic [4:0] index_char,
  input  logic [7:0] data_mode0,
  input  logic [7:0] data_mode1,
  input  logic [7:0] data_mode2,
  input  logic [7:0] data_mode3,
  output logic [7:0] data_char,
  output logic [3:0] sw_mode0,
  output logic [3:0] sw_mode1,
  output logic [3:0] sw_mode2,
  output logic [3:0] sw_mode3,
  output logic [1:0] active_mode,
  output logic       busy
);

  localparam logic [4:0] LAST_INDEX = 5'(CHAR_NUM - 1);

  arb_state_t state, state_nx;
  logic [1:0] active_nx;
  logic [1:0] target;
  logic [4:0] prev_index;
  logic       fb;
  logic       change;
  logic       qualified;
  logic [7:0] mode_char;
  logic       run_gate;

  mode_select_qualifier #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_qualifier (
    .clk        (clk),
    .rst        (rst),
    .dip_sw     (dip_sw),
    .active_mode(active_mode),
    .in_run     (state == RUN),
    .in_settle  (state == SETTLE),
    .change     (change),
    .target     (target),
    .qualified  (qualified)
  );

  assign fb = (prev_index == LAST_INDEX) && (index_char == 5'd0);

  // A decode change always takes priority over a frame boundary in the same cycle.
  always_comb begin
    state_nx  = state;
    active_nx = active_mode;
    case (state)
      RUN: begin
        if (change) state_nx = SETTLE;
      end
      SETTLE: begin
        if (qualified) state_nx = (target == active_mode) ? RUN : WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (change) begin
          state_nx = SETTLE;
        end else if (fb) begin
`ifdef MODE_ARB_BLANK_EN
          state_nx = BLANK;
`else
          state_nx  = RUN;
          active_nx = target;
`endif
        end
      end
      BLANK: begin
        if (change) begin
          state_nx = SETTLE;
        end else if (fb) begin
          state_nx  = RUN;
          active_nx = target;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    mode_char = data_mode0;
    case (active_mode)
      MODE_WATCH:     mode_char = data_mode0;
      MODE_SET:       mode_char = data_mode1;
      MODE_ALARM:     mode_char = data_mode2;
      MODE_STOPWATCH: mode_char = data_mode3;
      default:        mode_char = data_mode0;
    endcase
  end

  // Switch gating looks at the pre-transition state so a pulse on the exit cycle reaches the old mode.
  assign run_gate = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      active_mode <= MODE_WATCH;
      busy        <= 1'b0;
      prev_index  <= 5'd0;
      data_char   <= BLANK_CHAR;
      sw_mode0    <= 4'd0;
      sw_mode1    <= 4'd0;
      sw_mode2    <= 4'd0;
      sw_mode3    <= 4'd0;
    end else begin
      state       <= state_nx;
      active_mode <= active_nx;
      busy        <= (state_nx != RUN);
      prev_index  <= index_char;
`ifdef MODE_ARB_BLANK_EN
      data_char   <= (state == BLANK) ? BLANK_CHAR : mode_char;
`else
      data_char   <= mode_char;
`endif
      sw_mode0    <= (run_gate && active_mode == MODE_WATCH)     ? sw_pulse : 4'd0;
      sw_mode1    <= (run_gate && active_mode == MODE_SET)       ? sw_pulse : 4'd0;
      sw_mode2    <= (run_gate && active_mode == MODE_ALARM)     ? sw_pulse : 4'd0;
      sw_mode3    <= (run_gate && active_mode == MODE_STOPWATCH) ? sw_pulse : 4'd0;
    end
  end

endmodule

// File: tb/tb_mode_arbiter.sv
// tb/tb_mode_arbiter.sv - scoreboard bench for mode_arbiter with a cycle reference model
module tb_mode_arbiter;

  localparam int SETTLE = 8;
  localparam int NCHAR  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dip_sw;
  logic [3:0] sw_pulse;
  logic [4:0] index_char;
  logic [7:0] data_mode0, data_mode1, data_mode2, data_mode3;
  logic [7:0] data_char;
  logic [3:0] sw_mode0, sw_mode1, sw_mode2, sw_mode3;
  logic [1:0] active_mode;
  logic       busy;

  always #5 clk = ~clk;

  mode_arbiter #(
    .SETTLE_CYC(SETTLE),
    .CHAR_NUM  (NCHAR),
    .BLANK_CHAR(8'h20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dip_sw     (dip_sw),
    .sw_pulse   (sw_pulse),
    .index_char (index_char),
    .data_mode0 (data_mode0),
    .data_mode1 (data_mode1),
    .data_mode2 (data_mode2),
    .data_mode3 (data_mode3),
    .data_char  (data_char),
    .sw_mode0   (sw_mode0),
    .sw_mode1   (sw_mode1),
    .sw_mode2   (sw_mode2),
    .sw_mode3   (sw_mode3),
    .active_mode(active_mode),
    .busy       (busy)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] sw;
    logic [1:0]  active;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model: 0 run, 1 settle, 2 wait frame, 3 blank
  int   m_state, m_active, m_target, m_cnt, m_prev;
  int   idx = 0;
  bit   rand_data = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dec(input logic [3:0] d);
    if (d == 4'b0001) return 1;
    if (d == 4'b0010) return 2;
    if (d == 4'b0100) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_active = 0; m_target = 0; m_cnt = 0; m_prev = 0;
  endtask

  task automatic step(input logic [3:0] dip, input logic [3:0] pulse);
    exp_t       e;
    exp_t       g;
    int         d;
    bit         fb;
    logic [7:0] dm [4];
    dip_sw     = dip;
    sw_pulse   = pulse;
    index_char = idx[4:0];
    if (rand_data) begin
      data_mode0 = 8'($urandom); data_mode1 = 8'($urandom);
      data_mode2 = 8'($urandom); data_mode3 = 8'($urandom);
    end
    dm[0] = data_mode0; dm[1] = data_mode1; dm[2] = data_mode2; dm[3] = data_mode3;
    d  = dec(dip);
    fb = (m_prev == NCHAR - 1) && (idx == 0);
    e.data = (m_state == 3) ? 8'h20 : dm[m_active];
    e.sw   = 16'd0;
    if (m_state == 0) e.sw[m_active*4 +: 4] = pulse;
    case (m_state)
      0: if (d != m_active) begin m_target = d; m_cnt = 0; m_state = 1; end
      1: begin
        if (d != m_target) begin m_target = d; m_cnt = 0; end
        else if (m_cnt == SETTLE - 1) m_state = (m_target == m_active) ? 0 : 2;
        else m_cnt++;
      end
      default: begin
        if (d != m_target) begin
          m_target = d; m_cnt = 0; m_state = 1;
        end else if (fb) begin
`ifdef MODE_ARB_BLANK_EN
          if (m_state == 2) m_state = 3;
          else begin m_active = m_target; m_state = 0; end
`else
          m_active = m_target; m_state = 0;
`endif
        end
      end
    endcase
    m_prev   = idx;
    idx      = (idx + 1) % NCHAR;
    e.active = 2'(m_active);
    e.busy   = (m_state != 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check_eq("data_char", data_char, g.data);
    check_eq("sw_modes", {sw_mode3, sw_mode2, sw_mode1, sw_mode0}, g.sw);
    check_eq("active_mode", active_mode, g.active);
    check_eq("busy", busy, g.busy);
  endtask

  task automatic run(input int n, input logic [3:0] dip);
    for (int i = 0; i < n; i++) step(dip, 4'($urandom));
  endtask

  initial begin
    int goal;
    bit hit;
    rst = 1'b0; dip_sw = 4'b0000; sw_pulse = 4'd0; index_char = 5'd0;
    data_mode0 = 8'h41; data_mode1 = 8'h42; data_mode2 = 8'h43; data_mode3 = 8'h44;
    model_reset();

    // test 1: reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data_char", data_char, 8'h20);
    check_eq("rst_active", active_mode, 2'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_sw", {sw_mode3, sw_mode2, sw_mode1, sw_mode0}, 16'd0);
    rst = 1'b1;
    step(4'b0000, 4'd0);
    check_eq("t1_data_41", data_char, 8'h41);
    rand_data = 1'b1;
    run(4, 4'b0000);

    // test 3: short glitch returns to RUN without a commit
    run(5, 4'b0001);
    run(40, 4'b0000);
    check_eq("t3_active", active_mode, 2'd0);
    check_eq("t3_busy", busy, 1'b0);

    // test 2: switch to alarm
    run(1, 4'b0010);
    check_eq("t2_busy_rise", busy, 1'b1);
    run(120, 4'b0010);
    check_eq("t2_active", active_mode, 2'd2);

    // test 4: pulse routing in stopwatch mode, then drop while busy
    run(120, 4'b0100);
    check_eq("t4_active", active_mode, 2'd3);
    step(4'b0100, 4'b0101);
    check_eq("t4_sw3", sw_mode3, 4'b0101);
    check_eq("t4_sw_other", {sw_mode2, sw_mode1, sw_mode0}, 12'd0);
    step(4'b0100, 4'b0000);
    check_eq("t4_sw3_clear", sw_mode3, 4'd0);
    for (int i = 0; i < 120; i++) step(4'b0001, 4'b0101);
    check_eq("t4_active_set", active_mode, 2'd1);

    // test 5: multi-hot decodes to watch
    run(120, 4'b0110);
    check_eq("t5_active", active_mode, 2'd0);

    // test 6: reset while a change is pending, then repeat the alarm switch
`ifdef MODE_ARB_BLANK_EN
    goal = 3;
`else
    goal = 2;
`endif
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step(4'b0010, 4'($urandom));
      if (m_state == goal) hit = 1'b1;
    end
    check_eq("t6_reach_pending", hit, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_rst_data", data_char, 8'h20);
    check_eq("t6_rst_active", active_mode, 2'd0);
    check_eq("t6_rst_busy", busy, 1'b0);
    check_eq("t6_rst_sw", {sw_mode3, sw_mode2, sw_mode1, sw_mode0}, 16'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run(120, 4'b0010);
    check_eq("t6_active", active_mode, 2'd2);
    check_eq("t6_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_arbiter.md
Name: mode_arbiter

Overview:
Arbitrates the shared LCD character path and the four user switches among the four display modes (watch, watch-set, alarm, stopwatch).
- Replaces the combinational dip_sw case mux in the top level.
- Qualifies dip_sw changes over a settle window, then switches only on an LCD frame boundary, optionally after one blank frame.
- Routes switch pulses to the active mode only.
- Sits between the mode blocks and lcd_driver.

Parameters:
SETTLE_CYC, 50000, clk cycles dip_sw must hold a new decoded value before it is accepted
CHAR_NUM, 32, characters per LCD frame; index_char wraps from CHAR_NUM-1 to 0
BLANK_CHAR, 8'h20, character emitted during a blank frame

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
dip_sw  in  4  mode select switches
sw_pulse  in  4  debounced switch outputs
index_char  in  5  current character index from lcd_driver
data_mode0  in  8  character from watch mode
data_mode1  in  8  character from watch-set mode
data_mode2  in  8  character from alarm mode
data_mode3  in  8  character from stopwatch mode
data_char  out  8  character to lcd_driver
sw_mode0  out  4  switches gated to mode 0
sw_mode1  out  4  switches gated to mode 1
sw_mode2  out  4  switches gated to mode 2
sw_mode3  out  4  switches gated to mode 3
active_mode  out  2  currently committed mode
busy  out  1  high while a mode change is pending

Behaviour:
- Reset (rst=0, async): state RUN, active_mode=0, target=0, data_char=BLANK_CHAR, all sw_modeN=0, busy=0, settle counter=0, prev_index=0.
- Decode dip_sw: 4'b0001 -> 1; 4'b0010 -> 2; 4'b0100 -> 3; any other value (0000, 1000, multi-hot) -> 0.
- Frame boundary (fb): prev_index==CHAR_NUM-1 and index_char==0. prev_index is registered every cycle.
- FSM:
  - RUN: if decoded != active_mode, latch target=decoded, clear counter, go to SETTLE.
  - SETTLE: if decoded != target, re-latch target and clear counter (stay in SETTLE). Otherwise increment. When counter reaches SETTLE_CYC-1:
    - if target == active_mode, go to RUN;
    - else go to WAIT_FRAME.
  - WAIT_FRAME: if decoded != target, go to SETTLE with the new target. On fb, go to BLANK.
  - BLANK: if decoded != target, go to SETTLE. On the next fb, set active_mode=target and go to RUN.
  - A decode change and fb in the same cycle: the decode change wins.
- busy = (state != RUN), registered with the state.
- data_char is registered with 1-cycle latency:
  - BLANK: BLANK_CHAR;
  - all other states: data_modeN selected by active_mode.
- sw_modeN is registered with 1-cycle latency: equals sw_pulse when state==RUN and active_mode==N, else 0.
  - Pulses seen while busy are dropped, not queued.
  - A pulse in the same cycle RUN exits goes to the old mode. Gating uses the pre-transition state.
- Settle counter width is clog2(SETTLE_CYC). It saturates and never wraps.
- No combinational path from inputs to outputs. No latches.

Optional Feature:
Macro MODE_ARB_BLANK_EN.
- Defined: BLANK state exists as described.
- Undefined: WAIT_FRAME commits active_mode=target on fb and returns directly to RUN. data_char never forces BLANK_CHAR, and busy clears one frame earlier.

Decomposition:
- Shared package holds:
  - mode encodings MODE_WATCH=0, MODE_SET=1, MODE_ALARM=2, MODE_STOPWATCH=3;
  - state enum RUN/SETTLE/WAIT_FRAME/BLANK;
  - the BLANK_CHAR default.
- One natural sub-module, mode_select_qualifier: dip_sw decode plus the settle counter, producing target and a qualified strobe. The FSM and muxes stay in mode_arbiter.

Test Plan:
1. Reset with dip_sw=0000 and data_mode0=8'h41 -> data_char=8'h20 during reset; 8'h41 one cycle after release; active_mode=0; busy=0.
2. dip_sw 0000->0010 held (SETTLE_CYC=8 in test, index_char driven 0..31) -> busy rises in 1 cycle. First fb after 8 cycles enters BLANK: data_char=8'h20 for a whole frame. active_mode=2 at the second fb, then data_char=data_mode2.
3. dip_sw 0000->0001 for 5 cycles, then back to 0000 (SETTLE_CYC=8) -> after settling, returns to RUN with no blank frame; active_mode stays 0.
4. In RUN with mode 3, sw_pulse=4'b0101 for 1 cycle -> sw_mode3=4'b0101 for 1 cycle next cycle, other sw_modeN=0. The same pulse during BLANK -> all sw_modeN stay 0.
5. dip_sw=0110 (multi-hot) -> decodes to mode 0; with active_mode=1, transitions to mode 0 through the full sequence.
6. rst asserted during BLANK -> immediately RUN, active_mode=0, busy=0, data_char=8'h20. Repeat test 2 with MODE_ARB_BLANK_EN undefined -> commit at the first fb and no 8'h20 frame.
